up_prog_loader: RTL
===================

Name: up_prog_loader

Overview:
Program loader and memory-port arbiter for the 8-bit accumulator microprocessor.
- Owns the single-port 32x8 program/data RAM.
- Streams a program image into the RAM over a byte handshake while holding the control unit in reset.
- Zero-fills the unused addresses, releases the CPU, then passes CPU memory traffic through until the next load request.
- Sits between uP_CU/datapath and the RAM macro.

Parameters:
ADDR_W, 5, RAM address width
DATA_W, 8, RAM data width
DEPTH, 32, number of RAM words (must equal 2**ADDR_W)

Ports:
CLOCK  in  1  system clock, rising edge
RESET_N  in  1  asynchronous active-low reset
LOAD_REQ  in  1  request a new program load (level, sampled per cycle)
LD_VALID  in  1  loader byte valid
LD_DATA  in  DATA_W  loader byte
LD_LAST  in  1  marks final byte of image, qualified by LD_VALID
LD_READY  out  1  loader byte accepted when LD_VALID&LD_READY
CPU_ADDR  in  ADDR_W  CPU memory address
CPU_WDATA  in  DATA_W  CPU write data
CPU_WR  in  1  CPU write strobe (MemWr)
CPU_HALT  in  1  Halt from control unit
CPU_RDATA  out  DATA_W  read data to CPU
CPU_RESET_N  out  1  active-low reset to control unit/datapath
MEM_ADDR  out  ADDR_W  RAM address
MEM_WDATA  out  DATA_W  RAM write data
MEM_WE  out  1  RAM write enable
MEM_RDATA  in  DATA_W  RAM read data
BUSY  out  1  high in LOAD, FILL, START
DONE  out  1  one-cycle pulse when the CPU is released
LOAD_CNT  out  ADDR_W+1  bytes accepted in the current/last load (0..32)
STATE  out  3  current state encoding, for debug

Behaviour:
- States: IDLE=0, LOAD=1, FILL=2, START=3, RUN=4, HALTED=5. Codes 6 and 7 go to IDLE.
- Reset (async, RESET_N=0):
  - state=IDLE, addr counter=0, LOAD_CNT=0.
  - CPU_RESET_N=0, DONE=0, LD_READY=0, MEM_WE=0.
- IDLE:
  - CPU held (CPU_RESET_N=0).
  - LOAD_REQ=1 -> LOAD next cycle; addr counter and LOAD_CNT cleared.
- LOAD:
  - LD_READY=1.
  - Each handshake writes LD_DATA to MEM[addr] in the same cycle (MEM_WE=1, MEM_ADDR=addr), then addr++ and LOAD_CNT++.
  - Handshake with LD_LAST=1 and addr<DEPTH-1 -> FILL.
  - Handshake at addr=DEPTH-1 -> START regardless of LD_LAST; no wrap, excess bytes never accepted.
  - Handshake at addr=DEPTH-1 with LD_LAST=1 -> START (no fill).
  - No LD_VALID -> stay in LOAD, no write.
- FILL:
  - LD_READY=0.
  - Writes 0 to MEM[addr] every cycle, addr++.
  - After the write at DEPTH-1 -> START. LOAD_CNT frozen.
- START:
  - One cycle. DONE=1, no write, CPU_RESET_N still 0.
  - -> RUN.
- CPU_RESET_N is registered: 1 exactly while state is RUN or HALTED, so it rises on the clock edge entering RUN.
- RUN and HALTED:
  - MEM_ADDR=CPU_ADDR, MEM_WDATA=CPU_WDATA, MEM_WE=CPU_WR (combinational mux on state).
  - In all other states CPU_WR is ignored.
  - CPU_HALT=1 in RUN -> HALTED. HALTED is held until LOAD_REQ.
- LOAD_REQ in RUN or HALTED -> LOAD next cycle. CPU_RESET_N falls on that same edge. LOAD_REQ has priority over CPU_HALT.
- LOAD_REQ in LOAD, FILL or START is ignored.
- CPU_RDATA=MEM_RDATA in all states.
- RESET_N asserted mid-load -> IDLE immediately. RAM contents are left as written; no fill.
- Only LOAD_REQ, CPU_HALT and LD_* drive transitions. The mux path is purely combinational from state.

Decomposition:
- Package up_pkg:
  - ADDR_W/DATA_W/DEPTH defaults.
  - State localparams LDR_IDLE..LDR_HALTED and STATE width 3.
  - Shared with uP_CU for its state constants.
- Sub-module up_mem_mux (combinational 2:1 RAM port select, loader vs CPU). Everything else lives in up_prog_loader.

Test Plan:
- Reset then LOAD_REQ, stream 3 bytes 0xA1,0xB2,0xC3 with LD_LAST on the third:
  - MEM[0..2]=A1,B2,C3 and MEM[3..31]=00.
  - LOAD_CNT=3, FILL lasts 29 cycles, DONE pulses once, CPU_RESET_N rises the edge after DONE.
- Stream 40 bytes with no LD_LAST:
  - Exactly 32 accepted, LD_READY=0 after the 32nd, LOAD_CNT=32, no FILL, MEM[31]=byte 31, no write to MEM[0] past the end.
- LD_VALID toggling every other cycle with data 0x10..0x14:
  - Writes only on handshake cycles, addresses consecutive 0..4, LOAD_CNT=5.
- RUN with CPU_WR=1, CPU_ADDR=0x1F, CPU_WDATA=0x5A:
  - MEM[31]=0x5A. The same stimulus in IDLE or FILL leaves MEM[31] unchanged.
- RUN, CPU_HALT=1 -> STATE=5. Then LOAD_REQ and CPU_HALT together in RUN:
  - Next STATE=1, CPU_RESET_N=0 on that edge.
- RESET_N pulsed low after 4 bytes accepted:
  - STATE=0, LOAD_CNT=0, CPU_RESET_N=0 asynchronously, MEM[0..3] retained, MEM[4] untouched.

Source files
------------

// File: rtl/up_pkg.sv
// Shared constants for the 8-bit accumulator microprocessor: memory geometry
// and the program-loader state encoding (also used by uP_CU).
package up_pkg;

   localparam int ADDR_W  = 5;
   localparam int DATA_W  = 8;
   localparam int DEPTH   = 32;
   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      LDR_IDLE   = 3'd0,
      LDR_LOAD   = 3'd1,
      LDR_FILL   = 3'd2,
      LDR_START  = 3'd3,
      LDR_RUN    = 3'd4,
      LDR_HALTED = 3'd5
   } ldr_state_e;

endpackage

// File: rtl/up_mem_mux.sv
// Combinational RAM port select: the loader owns the port until the CPU is
// released, after which CPU address/data/write pass straight through.
module up_mem_mux
   import up_pkg::*;
#(
   parameter int ADDR_W = up_pkg::ADDR_W,
   parameter int DATA_W = up_pkg::DATA_W
) (
   input  logic              sel_cpu,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we
);

   assign mem_addr  = sel_cpu ? cpu_addr  : ldr_addr;
   assign mem_wdata = sel_cpu ? cpu_wdata : ldr_wdata;
   assign mem_we    = sel_cpu ? cpu_we    : ldr_we;

endmodule

// File: rtl/up_prog_loader.sv
// Program loader and RAM-port arbiter: streams an image into RAM with the CPU
// held in reset, zero-fills the remainder, then hands the port to the CPU.
module up_prog_loader
   import up_pkg::*;
#(
   parameter int ADDR_W = up_pkg::ADDR_W,
   parameter int DATA_W = up_pkg::DATA_W,
   parameter int DEPTH  = up_pkg::DEPTH
) (
   input  logic              CLOCK,
   input  logic              RESET_N,
   input  logic              LOAD_REQ,
   input  logic              LD_VALID,
   input  logic [DATA_W-1:0] LD_DATA,
   input  logic              LD_LAST,
   output logic              LD_READY,
   input  logic [ADDR_W-1:0] CPU_ADDR,
   input  logic [DATA_W-1:0] CPU_WDATA,
   input  logic              CPU_WR,
   input  logic              CPU_HALT,
   output logic [DATA_W-1:0] CPU_RDATA,
   output logic              CPU_RESET_N,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [DATA_W-1:0] MEM_WDATA,
   output logic              MEM_WE,
   input  logic [DATA_W-1:0] MEM_RDATA,
   output logic              BUSY,
   output logic              DONE,
   output logic [ADDR_W:0]   LOAD_CNT,
   output logic [2:0]        STATE
);

   ldr_state_e        state;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   load_cnt;
   logic              cpu_reset_n;
   logic              handshake;
   logic              at_end;
   logic              sel_cpu;
   logic              ldr_we;
   logic [DATA_W-1:0] ldr_wdata;

   assign LD_READY  = (state == LDR_LOAD);
   assign handshake = LD_VALID && LD_READY;
   assign at_end    = (addr == ADDR_W'(DEPTH - 1));
   assign sel_cpu   = (state == LDR_RUN) || (state == LDR_HALTED);
   assign ldr_we    = handshake || (state == LDR_FILL);
   assign ldr_wdata = (state == LDR_FILL) ? '0 : LD_DATA;

   assign BUSY        = (state == LDR_LOAD) || (state == LDR_FILL) || (state == LDR_START);
   assign DONE        = (state == LDR_START);
   assign CPU_RESET_N = cpu_reset_n;
   assign CPU_RDATA   = MEM_RDATA;
   assign LOAD_CNT    = load_cnt;
   assign STATE       = state;

   // cpu_reset_n is updated alongside state so it is high exactly in RUN/HALTED
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state       <= LDR_IDLE;
         addr        <= '0;
         load_cnt    <= '0;
         cpu_reset_n <= 1'b0;
      end else begin
         case (state)
            LDR_IDLE: begin
               if (LOAD_REQ) begin
                  state    <= LDR_LOAD;
                  addr     <= '0;
                  load_cnt <= '0;
               end
            end
            LDR_LOAD: begin
               if (handshake) begin
                  addr     <= addr + 1'b1;
                  load_cnt <= load_cnt + 1'b1;
                  if (at_end)
                     state <= LDR_START;
                  else if (LD_LAST)
                     state <= LDR_FILL;
               end
            end
            LDR_FILL: begin
               addr <= addr + 1'b1;
               if (at_end)
                  state <= LDR_START;
            end
            LDR_START: begin
               state       <= LDR_RUN;
               cpu_reset_n <= 1'b1;
            end
            LDR_RUN, LDR_HALTED: begin
               if (LOAD_REQ) begin
                  state       <= LDR_LOAD;
                  addr        <= '0;
                  load_cnt    <= '0;
                  cpu_reset_n <= 1'b0;
               end else if ((state == LDR_RUN) && CPU_HALT) begin
                  state <= LDR_HALTED;
               end
            end
            default: begin
               state       <= LDR_IDLE;
               cpu_reset_n <= 1'b0;
            end
         endcase
      end
   end

   up_mem_mux #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem_mux (
      .sel_cpu   (sel_cpu),
      .ldr_addr  (addr),
      .ldr_wdata (ldr_wdata),
      .ldr_we    (ldr_we),
      .cpu_addr  (CPU_ADDR),
      .cpu_wdata (CPU_WDATA),
      .cpu_we    (CPU_WR),
      .mem_addr  (MEM_ADDR),
      .mem_wdata (MEM_WDATA),
      .mem_we    (MEM_WE)
   );

endmodule
